// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM encoding and counter width helper.
// Used by the transmitter now and by the receiver later.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Bits needed to hold a counter running 0..n-1 (never less than one).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Handshake and serial-line bundle between an upstream producer and the UART transmitter.
interface uart_tx_param_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] din;
  logic              ready;
  logic              busy;
  logic              dout;
  logic              done;

  modport master (output start, output din, input ready, input busy, input dout, input done);
  modport slave  (input start, input din, output ready, output busy, output dout, output done);
endinterface

// File: rtl/uart_baud_tick.sv
// Clocks-per-bit divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear_i,
  output logic bit_end_o
);

  localparam int CNT_W = cnt_w(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_param
    $fatal(1, "uart_baud_tick: CLKS_PER_BIT must be at least 2");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bit_end_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_W data bits LSB first,
// optional even/odd parity and one or two stop bits, with start/ready handshake.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           n_rst,
  uart_tx_param_if.slave tx
);

  localparam int IDX_W = cnt_w(DATA_W);
  localparam int STP_W = cnt_w(STOP_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [STP_W-1:0] LAST_STP = STP_W'(STOP_BITS - 1);

  if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 2 ||
      PARITY < 0 || PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
    $fatal(1, "uart_tx_param: illegal parameter set");
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [STP_W-1:0]  stp_q, stp_d;
  logic              par_q, par_d;
  logic              dout_q, dout_d;
  logic              done_q, done_d;
  logic              bit_end;
  logic              accept;

  assign accept = (state_q == S_IDLE) && tx.start;

  // Held in clear while idle so every frame starts on a fresh bit period.
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear_i   (state_q == S_IDLE),
    .bit_end_o (bit_end)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (tx.start) state_d = S_START;
      S_START:  if (bit_end) state_d = S_DATA;
      S_DATA:   if (bit_end && (idx_q == LAST_IDX))
                  state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (bit_end && (stp_q == LAST_STP)) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    stp_d   = stp_q;
    par_d   = par_q;
    if (accept) begin
      shift_d = tx.din;
      idx_d   = '0;
      stp_d   = '0;
      par_d   = (^tx.din) ^ (PARITY == PAR_ODD);
    end else if (bit_end) begin
      if (state_q == S_DATA) begin
        shift_d = shift_q >> 1;
        idx_d   = idx_q + 1'b1;
      end
      if (state_q == S_STOP) stp_d = stp_q + 1'b1;
    end
  end

  // Line level is decided from the next state so dout itself can be a flop.
  always_comb begin
    dout_d = 1'b1;
    case (state_d)
      S_START:  dout_d = 1'b0;
      S_DATA:   dout_d = shift_d[0];
      S_PARITY: dout_d = par_d;
      default:  dout_d = 1'b1;
    endcase
    done_d = (state_q == S_STOP) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      idx_q  <= '0;
      stp_q  <= '0;
      dout_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      stp_q  <= stp_d;
      dout_q <= dout_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  assign tx.ready = (state_q == S_IDLE);
  assign tx.busy  = (state_q != S_IDLE);
  assign tx.dout  = dout_q;
  assign tx.done  = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Four transmitter configurations driven from one stimulus process; a monitor decodes
// each serial line cycle by cycle against frames predicted from the word and parameters.
module tb_uart_tx_param;

  localparam int NDUT = 4;

  typedef struct {
    int         d;
    logic [8:0] w;
    int         stamp;
  } exp_t;

  logic       clk = 1'b0;
  int         cyc = 0;
  logic [3:0] nrst = '0;
  logic [3:0] st = '0;
  logic [8:0] dv [NDUT];
  logic [3:0] rst_seen = '0;
  logic [3:0] m_dout, m_ready, m_busy, m_done;

  exp_t       expq [$];
  int         nxt [NDUT];
  int         checks = 0;
  int         errors = 0;
  logic       fin_req = 1'b0;

  logic [3:0] infr = '0;
  int         fstart [NDUT];
  logic [8:0] fword [NDUT];

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= nrst;
  end

  uart_tx_param_if #(.DATA_W(8)) ifc0 ();
  uart_tx_param_if #(.DATA_W(8)) ifc1 ();
  uart_tx_param_if #(.DATA_W(8)) ifc2 ();
  uart_tx_param_if #(.DATA_W(5)) ifc3 ();

  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(16), .PARITY(0), .STOP_BITS(1))
    dut0 (.clk(clk), .n_rst(nrst[0]), .tx(ifc0));
  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1))
    dut1 (.clk(clk), .n_rst(nrst[1]), .tx(ifc1));
  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1))
    dut2 (.clk(clk), .n_rst(nrst[2]), .tx(ifc2));
  uart_tx_param #(.DATA_W(5), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2))
    dut3 (.clk(clk), .n_rst(nrst[3]), .tx(ifc3));

  assign ifc0.start = st[0];
  assign ifc1.start = st[1];
  assign ifc2.start = st[2];
  assign ifc3.start = st[3];
  assign ifc0.din   = dv[0][7:0];
  assign ifc1.din   = dv[1][7:0];
  assign ifc2.din   = dv[2][7:0];
  assign ifc3.din   = dv[3][4:0];
  assign m_dout  = {ifc3.dout,  ifc2.dout,  ifc1.dout,  ifc0.dout};
  assign m_ready = {ifc3.ready, ifc2.ready, ifc1.ready, ifc0.ready};
  assign m_busy  = {ifc3.busy,  ifc2.busy,  ifc1.busy,  ifc0.busy};
  assign m_done  = {ifc3.done,  ifc2.done,  ifc1.done,  ifc0.done};

  function automatic int dw_of(input int d);
    return (d == 3) ? 5 : 8;
  endfunction
  function automatic int cpb_of(input int d);
    return (d == 0) ? 16 : 4;
  endfunction
  function automatic int par_of(input int d);
    return (d == 1) ? 1 : ((d == 2) ? 2 : 0);
  endfunction
  function automatic int sb_of(input int d);
    return (d == 3) ? 2 : 1;
  endfunction
  function automatic int flen(input int d);
    return (1 + dw_of(d) + ((par_of(d) != 0) ? 1 : 0) + sb_of(d)) * cpb_of(d);
  endfunction

  // Serial bit list of a whole frame, index 0 = start bit; unused tail stays high.
  function automatic logic [15:0] frame_bits(input int d, input logic [8:0] w);
    logic [15:0] b = '1;
    logic        p = 1'b0;
    int          n = dw_of(d);
    b[0] = 1'b0;
    for (int i = 0; i < n; i++) begin
      b[1 + i] = w[i];
      p = p ^ w[i];
    end
    if (par_of(d) == 2) p = ~p;
    if (par_of(d) != 0) b[1 + n] = p;
    return b;
  endfunction

  function automatic void chk(input int d, input string nm, input logic [31:0] act,
                              input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got 'h%0h, expected 'h%0h", nm, d, cyc, act, req);
    end
  endfunction

  function automatic int find_exp(input int d);
    for (int i = 0; i < expq.size(); i++)
      if (expq[i].d == d) return i;
    return -1;
  endfunction

  function automatic int count_exp(input int d);
    int n = 0;
    for (int i = 0; i < expq.size(); i++)
      if (expq[i].d == d) n++;
    return n;
  endfunction

  task automatic mon_one(input int d);
    int          k;
    int          idx;
    logic [15:0] bits;
    if (!rst_seen[d]) begin
      chk(d, "reset_state", {m_dout[d], m_ready[d], m_busy[d], m_done[d]}, 4'b1100);
      infr[d] = 1'b0;
      return;
    end
    if (!infr[d]) begin
      if (!m_busy[d]) begin
        chk(d, "idle_line", {m_dout[d], m_ready[d], m_busy[d], m_done[d]}, 4'b1100);
        return;
      end
      idx = find_exp(d);
      if (idx < 0) begin
        chk(d, "unexpected_frame", 1, 0);
        fword[d] = '0;
      end else begin
        chk(d, "start_time", cyc, expq[idx].stamp);
        fword[d] = expq[idx].w;
        expq.delete(idx);
      end
      infr[d]   = 1'b1;
      fstart[d] = cyc;
    end
    k = cyc - fstart[d];
    if (k < flen(d)) begin
      bits = frame_bits(d, fword[d]);
      chk(d, "dout_bit", m_dout[d], bits[k / cpb_of(d)]);
      chk(d, "busy_flags", {m_ready[d], m_busy[d], m_done[d]}, 3'b010);
    end else begin
      chk(d, "frame_end", {m_dout[d], m_ready[d], m_busy[d], m_done[d]}, 4'b1101);
      infr[d] = 1'b0;
    end
  endtask

  initial begin : monitor
    bit fin_done = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) mon_one(d);
      if (fin_req && !fin_done) begin
        for (int d = 0; d < NDUT; d++) begin
          chk(d, "pending_frames", count_exp(d), 0);
          chk(d, "frame_open", infr[d], 0);
        end
        fin_done = 1'b1;
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input int d, input logic [8:0] w, input int stamp);
    exp_t e;
    e.d     = d;
    e.w     = w;
    e.stamp = stamp;
    expq.push_back(e);
  endtask

  // One frame from an idle DUT; optional stray start pulse while the frame is on the line.
  task automatic frame(input int d, input logic [8:0] w, input int gap, input bit poke);
    int c, s, f, x;
    wait_until(nxt[d] + gap);
    c     = cyc;
    st[d] = 1'b1;
    dv[d] = w;
    push_exp(d, w, c + 1);
    wait_until(c + 1);
    st[d] = 1'b0;
    dv[d] = 9'($urandom);
    s = c + 1;
    f = flen(d);
    if (poke) begin
      x = s + int'($urandom_range(0, f - 2));
      wait_until(x);
      st[d] = 1'b1;
      wait_until(x + 1);
      st[d] = 1'b0;
    end
    nxt[d] = s + f;
  endtask

  initial begin : stimulus
    int c, s, f;
    for (int d = 0; d < NDUT; d++) dv[d] = '0;
    wait_until(3);
    nrst = '1;
    for (int d = 0; d < NDUT; d++) nxt[d] = 3;
    nxt[0] = 8;

    // Single frame of 0x81 at default parameters, then a quiet stretch.
    frame(0, 9'h081, 0, 1'b0);
    wait_until(nxt[0] + 200);
    nxt[0] = cyc;

    // start held across two frames; din changes mid-frame to the second word.
    wait_until(nxt[0]);
    c = cyc; s = c + 1; f = flen(0);
    st[0] = 1'b1;
    dv[0] = 9'h081;
    push_exp(0, 9'h081, s);
    wait_until(s + 50);
    dv[0] = 9'h0A5;
    push_exp(0, 9'h0A5, s + f + 1);
    wait_until(s + f + 1);
    st[0] = 1'b0;
    nxt[0] = s + f + 1 + f;

    // Reset pulse in the 50th cycle of a frame, then a clean 0x3C.
    wait_until(nxt[0]);
    c = cyc; s = c + 1;
    st[0] = 1'b1;
    dv[0] = 9'h0FF;
    push_exp(0, 9'h0FF, s);
    wait_until(s);
    st[0] = 1'b0;
    wait_until(s + 49);
    nrst[0] = 1'b0;
    wait_until(s + 50);
    nrst[0] = 1'b1;
    nxt[0] = s + 51;
    frame(0, 9'h03C, 1, 1'b0);

    frame(0, 9'($urandom), 0, 1'b1);
    frame(0, 9'($urandom), 2, 1'b1);
    repeat (8) frame(0, 9'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    frame(1, 9'h081, 0, 1'b0);
    repeat (12) frame(1, 9'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    frame(2, 9'h081, 0, 1'b0);
    repeat (12) frame(2, 9'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    frame(3, 9'b0_0001_0110, 0, 1'b0);
    repeat (12) frame(3, 9'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    wait_until(nxt[3] + 20);
    fin_req = 1'b1;
    wait_until(cyc + 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
